// File: rtl/dmem_resp.sv
// Data-memory responder: single outstanding request, byte-masked writes and word reads
// on a word-organised RAM, with a one-cycle response after a fixed configurable latency.
module dmem_resp #(
  parameter int unsigned AW      = 10,
  parameter int unsigned LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cs_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_wem_i,
  input  logic [31:0] mem_din_i,
  input  logic [31:0] mem_addr_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] mem_dout_o,
  output logic        err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam int unsigned Depth    = 2 ** AW;
  localparam logic [32:0] ByteSpan = 33'(Depth) << 2;
  localparam logic [3:0]  CntInit  = 4'(LATENCY - 1);
  localparam bit          OneCycle = (LATENCY == 1);

  // Configuration guard: the 4-bit counter only covers 1..15, and the span must fit 32 bits.
  if (LATENCY < 1 || LATENCY > 15) begin : gen_bad_latency
    $error("dmem_resp: LATENCY must be in 1..15");
  end
  if (AW < 1 || AW > 29) begin : gen_bad_aw
    $error("dmem_resp: AW must be in 1..29");
  end

  logic [31:0] mem_q [Depth];

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] pend_data_q;
  logic        pend_err_q;
  logic        rvalid_q;
  logic [31:0] dout_q;
  logic        err_q;

  logic [31:0] off;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        accept;
  logic [31:0] rd_word;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        unused_off;

  // Unsigned wrap makes addresses below BASE land far out of range.
  assign off        = mem_addr_i - BASE;
  assign in_range   = {1'b0, off} < ByteSpan;
  assign idx        = off[AW+1:2];
  assign unused_off = ^{off[31:AW+2], off[1:0]};
  assign accept     = cs_i & ready_o;
  assign rd_word    = mem_q[idx];

  always_comb begin
    rsp_err  = ~in_range;
    rsp_data = '0;
    if (in_range && !mem_we_i) begin
      rsp_data = rd_word;
    end
  end

  // Writes commit at the accept edge, so any later read already sees them.
  always_ff @(posedge clk) begin
    if (accept && mem_we_i && in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (mem_wem_i[n]) begin
          mem_q[idx][8*n +: 8] <= mem_din_i[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      dout_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      dout_q   <= '0;
      err_q    <= 1'b0;
      unique case (state_q)
        StIdle, StResp: begin
          if (accept) begin
            if (OneCycle) begin
              state_q  <= StResp;
              rvalid_q <= 1'b1;
              dout_q   <= rsp_data;
              err_q    <= rsp_err;
            end else begin
              state_q     <= StWait;
              cnt_q       <= CntInit;
              pend_data_q <= rsp_data;
              pend_err_q  <= rsp_err;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q  <= StResp;
            cnt_q    <= '0;
            rvalid_q <= 1'b1;
            dout_q   <= pend_data_q;
            err_q    <= pend_err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o    = (state_q != StWait);
  assign rvalid_o   = rvalid_q;
  assign mem_dout_o = dout_q;
  assign err_o      = err_q;

  a_resp_ready: assert property (@(posedge clk) disable iff (!rstn) rvalid_o |-> ready_o);
  a_quiet_idle: assert property (@(posedge clk) disable iff (!rstn)
                                 !rvalid_o |-> (mem_dout_o == '0 && !err_o));
  a_one_shot:   assert property (@(posedge clk) disable iff (!rstn)
                                 (rvalid_o && !OneCycle) |=> !rvalid_o);

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three instances at LATENCY 1, 2 and 3 share request fields
// but have their own chip selects; vectors run on the LATENCY=2 instance.
module tb_dmem_resp;

  logic        clk;
  logic        rstn;
  logic        cs [3];
  logic        we;
  logic [3:0]  wem;
  logic [31:0] din;
  logic [31:0] addr;
  logic        ready [3];
  logic        rvalid [3];
  logic [31:0] dout [3];
  logic        err [3];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_resp #(.AW(10), .LATENCY(1), .BASE(32'h0)) u_dut1 (
    .clk(clk), .rstn(rstn), .cs_i(cs[0]), .mem_we_i(we), .mem_wem_i(wem), .mem_din_i(din),
    .mem_addr_i(addr), .ready_o(ready[0]), .rvalid_o(rvalid[0]), .mem_dout_o(dout[0]),
    .err_o(err[0])
  );
  dmem_resp #(.AW(10), .LATENCY(2), .BASE(32'h0)) u_dut2 (
    .clk(clk), .rstn(rstn), .cs_i(cs[1]), .mem_we_i(we), .mem_wem_i(wem), .mem_din_i(din),
    .mem_addr_i(addr), .ready_o(ready[1]), .rvalid_o(rvalid[1]), .mem_dout_o(dout[1]),
    .err_o(err[1])
  );
  dmem_resp #(.AW(10), .LATENCY(3), .BASE(32'h0)) u_dut3 (
    .clk(clk), .rstn(rstn), .cs_i(cs[2]), .mem_we_i(we), .mem_wem_i(wem), .mem_din_i(din),
    .mem_addr_i(addr), .ready_o(ready[2]), .rvalid_o(rvalid[2]), .mem_dout_o(dout[2]),
    .err_o(err[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on instance sel; returns response data/err and latency (0 = timed out).
  task automatic req(input int sel, input logic w, input logic [3:0] m, input logic [31:0] d,
                     input logic [31:0] a, output logic [31:0] rd, output logic re,
                     output int lat);
    @(negedge clk);
    chk("ready_before_req", {31'b0, ready[sel]}, 32'd1);
    cs[sel] = 1'b1; we = w; wem = m; din = d; addr = a;
    @(posedge clk);
    #1 cs[sel] = 1'b0;
    lat = 0; rd = '0; re = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rvalid[sel]) begin
        lat = i; rd = dout[sel]; re = err[sel];
        break;
      end
    end
    @(negedge clk);
    chk("clear_after_resp", {rvalid[sel], err[sel], dout[sel][29:0]}, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  m;
    logic [31:0] d;
    logic [31:0] a;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t        v [16];
  logic [31:0] rd;
  logic        re;
  int          lat;
  int          seen;
  logic [31:0] seen_data;

  initial begin
    checks = 0; errors = 0;
    v[0]  = '{1'b1, 4'hF, 32'h1111_1111, 32'h0000_0000, 1'b0, 32'h0};
    v[1]  = '{1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0000_0010, 1'b0, 32'h0};
    v[2]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0010, 1'b0, 32'hDEAD_BEEF};
    v[3]  = '{1'b1, 4'h1, 32'h0000_0055, 32'h0000_0010, 1'b0, 32'h0};
    v[4]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0010, 1'b0, 32'hDEAD_BE55};
    v[5]  = '{1'b0, 4'h0, 32'h0,         32'h0000_1000, 1'b1, 32'h0};
    v[6]  = '{1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_1000, 1'b1, 32'h0};
    v[7]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0000, 1'b0, 32'h1111_1111};
    v[8]  = '{1'b1, 4'h0, 32'h0,         32'h0000_0010, 1'b0, 32'h0};
    v[9]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0013, 1'b0, 32'hDEAD_BE55};
    v[10] = '{1'b1, 4'hF, 32'h0,         32'h0000_0014, 1'b0, 32'h0};
    v[11] = '{1'b1, 4'hA, 32'hAABB_CCDD, 32'h0000_0014, 1'b0, 32'h0};
    v[12] = '{1'b0, 4'h0, 32'h0,         32'h0000_0014, 1'b0, 32'hAA00_CC00};
    v[13] = '{1'b1, 4'hF, 32'hCAFE_F00D, 32'h0000_0FFC, 1'b0, 32'h0};
    v[14] = '{1'b0, 4'h0, 32'h0,         32'h0000_0FFC, 1'b0, 32'hCAFE_F00D};
    v[15] = '{1'b0, 4'h0, 32'h0,         32'hFFFF_FFFC, 1'b1, 32'h0};

    // Reset with a read request held on the LATENCY=2 instance.
    rstn = 1'b0;
    cs[0] = 1'b0; cs[1] = 1'b1; cs[2] = 1'b0;
    we = 1'b0; wem = 4'h0; din = '0; addr = 32'h10;
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'b0, ready[1]}, 32'd1);
    chk("reset_rvalid", {31'b0, rvalid[1]}, 32'd0);
    chk("reset_dout_err", {err[1], dout[1][30:0]}, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1 cs[1] = 1'b0;
    @(negedge clk);
    chk("t1_cycle2_rvalid", {31'b0, rvalid[1]}, 32'd0);
    @(negedge clk);
    chk("t1_cycle3_rvalid", {31'b0, rvalid[1]}, 32'd1);
    @(negedge clk);
    chk("t1_cycle4_rvalid", {31'b0, rvalid[1]}, 32'd0);

    // Table vectors on LATENCY=2.
    for (int i = 0; i < 16; i++) begin
      req(1, v[i].w, v[i].m, v[i].d, v[i].a, rd, re, lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd2);
      chk($sformatf("vec%0d_dout", i), rd, v[i].exp_dout);
      chk($sformatf("vec%0d_err", i), {31'b0, re}, {31'b0, v[i].exp_err});
    end

    // LATENCY=1 back-to-back write then read of the same word.
    @(negedge clk);
    cs[0] = 1'b1; we = 1'b1; wem = 4'hF; din = 32'h1234_5678; addr = 32'h20;
    @(posedge clk);
    #1 we = 1'b0; din = '0;
    @(negedge clk);
    chk("b2b_wr_rvalid", {31'b0, rvalid[0]}, 32'd1);
    chk("b2b_wr_dout_err", {err[0], dout[0][30:0]}, 32'd0);
    chk("b2b_ready", {31'b0, ready[0]}, 32'd1);
    @(posedge clk);
    #1 cs[0] = 1'b0;
    @(negedge clk);
    chk("b2b_rd_rvalid", {31'b0, rvalid[0]}, 32'd1);
    chk("b2b_rd_dout", dout[0], 32'h1234_5678);
    chk("b2b_rd_err", {31'b0, err[0]}, 32'd0);
    @(negedge clk);
    chk("b2b_idle_rvalid", {31'b0, rvalid[0]}, 32'd0);

    // LATENCY=3: requests during WAIT must be ignored.
    req(2, 1'b1, 4'hF, 32'h0BAD_F00D, 32'h40, rd, re, lat);
    chk("l3_wr_latency", lat, 32'd3);
    req(2, 1'b1, 4'hF, 32'h55AA_55AA, 32'h44, rd, re, lat);
    @(negedge clk);
    cs[2] = 1'b1; we = 1'b0; addr = 32'h40;
    @(posedge clk);
    #1 we = 1'b1; wem = 4'hF; din = 32'h0; addr = 32'h44;
    seen = 0; seen_data = '0;
    @(negedge clk);
    chk("l3_wait_ready", {31'b0, ready[2]}, 32'd0);
    if (rvalid[2]) begin seen++; seen_data = dout[2]; end
    @(posedge clk);
    #1 we = 1'b0; addr = 32'h48;
    @(negedge clk);
    if (rvalid[2]) begin seen++; seen_data = dout[2]; end
    @(posedge clk);
    #1 cs[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rvalid[2]) begin seen++; seen_data = dout[2]; end
    end
    chk("l3_resp_count", seen, 32'd1);
    chk("l3_resp_data", seen_data, 32'h0BAD_F00D);
    req(2, 1'b0, 4'h0, 32'h0, 32'h44, rd, re, lat);
    chk("l3_ignored_write", rd, 32'h55AA_55AA);

    // Reset during WAIT drops the response but keeps the committed write.
    @(negedge clk);
    cs[1] = 1'b1; we = 1'b1; wem = 4'hF; din = 32'hA5A5_A5A5; addr = 32'h8;
    @(posedge clk);
    #1 cs[1] = 1'b0;
    seen = 0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    if (rvalid[1]) seen++;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rvalid[1]) seen++;
    end
    chk("rst_drop_rvalid", seen, 32'd0);
    req(1, 1'b0, 4'h0, 32'h0, 32'h8, rd, re, lat);
    chk("rst_write_kept", rd, 32'hA5A5_A5A5);
    chk("rst_read_latency", lat, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
